// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU load/store
// unit (port 0) and an auxiliary master such as a loader or DMA (port 1).
// One transaction is accepted per cycle. The memory is driven from registers,
// and read data returns to the owning port with a one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_we,
    output logic          mem_be,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state;
    state_t        state_next;

    // arbitration bookkeeping
    logic          last_owner;
    logic [3:0]    starve_cnt;
    logic          pick_m1;
    logic          accept;

    // fields of the winning request, muxed combinationally
    logic          sel_we;
    logic          sel_be;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // registered transaction that drives the memory during ACCESS
    logic          own_q;
    logic          we_q;
    logic          be_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          read_done;

    // Choose the winner for this cycle and mux its fields; word accesses are
    // aligned here so the memory never sees stray low address bits
    always_comb begin
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            if (RR_MODE != 0) begin
                pick_m1 = ~last_owner;
            end else begin
                pick_m1 = (starve_cnt == LIMIT);
            end
        end else begin
            pick_m1 = m1_req;
        end

        m0_gnt    = m0_req && !pick_m1;
        m1_gnt    = m1_req && pick_m1;
        accept    = m0_req || m1_req;

        sel_we    = pick_m1 ? m1_we    : m0_we;
        sel_be    = pick_m1 ? m1_be    : m0_be;
        sel_addr  = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
        if (!sel_be) begin
            sel_addr[1:0] = 2'b00;
        end
    end

    // State register; reset drops straight to IDLE, killing any live write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and write strobe; the strobe is only live while in ACCESS
    always_comb begin
        state_next = IDLE;
        mem_we     = 1'b0;
        if (accept) begin
            state_next = ACCESS;
        end
        if (state == ACCESS) begin
            mem_we = we_q;
        end
    end

    assign mem_be    = be_q;
    assign mem_a     = addr_q;
    assign mem_wd    = wdata_q;
    assign read_done = (state == ACCESS) && !we_q;

    // Capture the accepted transaction and remember who won for round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_owner <= 1'b1;
        end else if (accept) begin
            own_q      <= pick_m1;
            we_q       <= sel_we;
            be_q       <= sel_be;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            last_owner <= pick_m1;
        end
    end

    // Return read data to its owner at the edge that ends the read ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (read_done) begin
                if (own_q) begin
                    m1_rvalid <= 1'b1;
                    m1_rdata  <= mem_rd;
                end else begin
                    m0_rvalid <= 1'b1;
                    m0_rdata  <= mem_rd;
                end
            end
        end
    end

    // Count consecutive cycles port 1 waits under fixed priority, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (RR_MODE != 0) begin
            starve_cnt <= 4'd0;
        end else if (!m1_req || m1_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: one round-robin and one fixed-priority instance,
// each with its own behavioural memory, checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
    localparam int NRAND = 400;

    logic clk = 1'b0;
    logic rst_n;

    // index 0 drives the round-robin instance, index 1 the fixed-priority one
    logic [1:0]       m0_req, m1_req, m0_we, m1_we, m0_be, m1_be;
    logic [1:0][31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [1:0]       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_be;
    logic [1:0][31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [2][256];
    logic [31:0] ref_mem [2][256];

    int checks;
    int errors;

    // reference model state, one set per instance
    int          last_own [2];
    int          starve [2];
    bit          acc_v [2];
    int          acc_port [2];
    bit          acc_we [2];
    bit          acc_be [2];
    logic [31:0] acc_addr [2];
    logic [31:0] acc_wd [2];
    bit          ret_v [2];
    int          ret_port [2];
    logic [31:0] exp_rd [2][2];

    typedef struct {
        logic       m0_req;
        logic       m1_req;
        logic [1:0] exp_rr;
        logic [1:0] exp_fx;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .RR_MODE(1), .STARVE_LIMIT(LIMIT)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_be(m0_be[0]),
        .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
        .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_be(m1_be[0]),
        .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
        .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
        .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_a(mem_a[0]),
        .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
    );

    dmem_arbiter #(.AW(32), .DW(32), .RR_MODE(0), .STARVE_LIMIT(LIMIT)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_be(m0_be[1]),
        .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
        .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_be(m1_be[1]),
        .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
        .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
        .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_a(mem_a[1]),
        .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
    );

    // Memories start from a known pattern so reads of untouched words are predictable
    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mem[d][i] <= {8'h5A, 8'(d), 16'(i)};
    end

    // Memory write port: word or single byte lane, committed at the rising edge
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) begin
                if (mem_be[d])
                    mem[d][mem_a[d][9:2]][8*mem_a[d][1:0] +: 8] <= mem_wd[d][7:0];
                else
                    mem[d][mem_a[d][9:2]] <= mem_wd[d];
            end
        end
    end

    // Memory read port: registered at the falling edge, byte reads zero-extended
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_be[d])
                mem_rd[d] <= (mem[d][mem_a[d][9:2]] >> (8*mem_a[d][1:0])) & 32'hFF;
            else
                mem_rd[d] <= mem[d][mem_a[d][9:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0; m0_be = '0; m1_be = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic applyStimulus(input int d, input int port, input logic req, input logic we,
                                 input logic be, input logic [31:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            m0_req[d] = req; m0_we[d] = we; m0_be[d] = be; m0_addr[d] = addr; m0_wdata[d] = wd;
        end else begin
            m1_req[d] = req; m1_we[d] = we; m1_be[d] = be; m1_addr[d] = addr; m1_wdata[d] = wd;
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            last_own[d] = 1;
            starve[d]   = 0;
            acc_v[d]    = 1'b0;
            ret_v[d]    = 1'b0;
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
        end
    endtask

    // Who should win this cycle: instance 0 alternates, instance 1 favours port 0
    function automatic int modelWinner(input int d);
        if (m0_req[d] && m1_req[d]) begin
            if (d == 0) return (last_own[d] == 0) ? 1 : 0;
            return (starve[d] == LIMIT) ? 1 : 0;
        end
        if (m0_req[d]) return 0;
        if (m1_req[d]) return 1;
        return -1;
    endfunction

    // Compare every output of both instances against the model's expectation
    task automatic modelCheck();
        for (int d = 0; d < 2; d++) begin
            int w;
            logic [31:0] ea;
            w = modelWinner(d);
            checkOutput($sformatf("d%0d m0_gnt", d), m0_gnt[d], w == 0);
            checkOutput($sformatf("d%0d m1_gnt", d), m1_gnt[d], w == 1);
            checkOutput($sformatf("d%0d mem_we", d), mem_we[d], acc_v[d] && acc_we[d]);
            if (acc_v[d]) begin
                ea = acc_be[d] ? acc_addr[d] : (acc_addr[d] & ~32'h3);
                checkOutput($sformatf("d%0d mem_a", d), mem_a[d], ea);
                checkOutput($sformatf("d%0d mem_be", d), mem_be[d], acc_be[d]);
                if (acc_we[d])
                    checkOutput($sformatf("d%0d mem_wd", d), mem_wd[d], acc_wd[d]);
            end
            checkOutput($sformatf("d%0d m0_rvalid", d), m0_rvalid[d], ret_v[d] && ret_port[d] == 0);
            checkOutput($sformatf("d%0d m1_rvalid", d), m1_rvalid[d], ret_v[d] && ret_port[d] == 1);
            checkOutput($sformatf("d%0d m0_rdata", d), m0_rdata[d], exp_rd[d][0]);
            checkOutput($sformatf("d%0d m1_rdata", d), m1_rdata[d], exp_rd[d][1]);
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic modelUpdate();
        for (int d = 0; d < 2; d++) begin
            int w;
            int idx;
            int lane;
            logic [31:0] val;
            w = modelWinner(d);
            ret_v[d] = 1'b0;
            if (acc_v[d]) begin
                idx  = int'(acc_addr[d][9:2]);
                lane = int'(acc_addr[d][1:0]);
                if (acc_we[d]) begin
                    if (acc_be[d]) ref_mem[d][idx][8*lane +: 8] = acc_wd[d][7:0];
                    else           ref_mem[d][idx] = acc_wd[d];
                end else begin
                    val = acc_be[d] ? ((ref_mem[d][idx] >> (8*lane)) & 32'hFF) : ref_mem[d][idx];
                    ret_v[d] = 1'b1;
                    ret_port[d] = acc_port[d];
                    exp_rd[d][acc_port[d]] = val;
                end
            end
            acc_v[d] = (w >= 0);
            if (w == 0) begin
                acc_port[d] = 0; acc_we[d] = m0_we[d]; acc_be[d] = m0_be[d];
                acc_addr[d] = m0_addr[d]; acc_wd[d] = m0_wdata[d];
            end else if (w == 1) begin
                acc_port[d] = 1; acc_we[d] = m1_we[d]; acc_be[d] = m1_be[d];
                acc_addr[d] = m1_addr[d]; acc_wd[d] = m1_wdata[d];
            end
            if (w >= 0) last_own[d] = w;
            if (d == 1) begin
                if (!m1_req[d] || w == 1) starve[d] = 0;
                else if (starve[d] < LIMIT) starve[d]++;
            end
        end
    endtask

    task automatic toNegedge();
        @(negedge clk);
        modelCheck();
    endtask

    task automatic toPosedge();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        #1;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // {m0_req, m1_req, expected {m1_gnt,m0_gnt} round-robin, same for fixed priority}
        tbl[0]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[1]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[2]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[4]  = '{1'b1, 1'b1, 2'b01, 2'b10};
        tbl[5]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[6]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[7]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[8]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[9]  = '{1'b1, 1'b1, 2'b10, 2'b10};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 2'b01};
        tbl[11] = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b00};
        tbl[13] = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[14] = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[15] = '{1'b1, 1'b1, 2'b01, 2'b01};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                ref_mem[d][i] = {8'h5A, 8'(d), 16'(i)};

        clearInputs();
        modelReset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset d%0d gnt", d), {m1_gnt[d], m0_gnt[d]}, 0);
            checkOutput($sformatf("reset d%0d rvalid", d), {m1_rvalid[d], m0_rvalid[d]}, 0);
            checkOutput($sformatf("reset d%0d mem_we/be", d), {mem_we[d], mem_be[d]}, 0);
            checkOutput($sformatf("reset d%0d mem_a", d), mem_a[d], 0);
            checkOutput($sformatf("reset d%0d mem_wd", d), mem_wd[d], 0);
            checkOutput($sformatf("reset d%0d m0_rdata", d), m0_rdata[d], 0);
            checkOutput($sformatf("reset d%0d m1_rdata", d), m1_rdata[d], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Word write from port 0, then check it reaches memory word 4
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        toNegedge();
        checkOutput("A m0_gnt", m0_gnt[0], 1);
        toPosedge();
        clearInputs();
        toNegedge();
        checkOutput("A mem_we", mem_we[0], 1);
        checkOutput("A mem_a", mem_a[0], 32'h10);
        checkOutput("A mem_wd", mem_wd[0], 32'hDEADBEEF);
        toPosedge();
        toNegedge();
        checkOutput("A mem word4", mem[0][4], 32'hDEADBEEF);
        checkOutput("A no rvalid", {m1_rvalid[0], m0_rvalid[0]}, 0);
        toPosedge();

        // Word read back on port 0: rvalid two cycles after the accept
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        toNegedge();
        toPosedge();
        clearInputs();
        toNegedge();
        checkOutput("B early rvalid", m0_rvalid[0], 0);
        toPosedge();
        toNegedge();
        checkOutput("B m0_rvalid", m0_rvalid[0], 1);
        checkOutput("B m0_rdata", m0_rdata[0], 32'hDEADBEEF);
        checkOutput("B m1_rvalid", m1_rvalid[0], 0);
        toPosedge();
        toNegedge();
        checkOutput("B rvalid pulse", m0_rvalid[0], 0);
        checkOutput("B rdata hold", m0_rdata[0], 32'hDEADBEEF);
        toPosedge();

        // Byte write on port 1 then back-to-back unaligned word read
        applyStimulus(0, 1, 1'b1, 1'b1, 1'b1, 32'h13, 32'h000000AB);
        toNegedge();
        toPosedge();
        applyStimulus(0, 1, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0);
        toNegedge();
        checkOutput("C m1_gnt b2b", m1_gnt[0], 1);
        checkOutput("C mem_be", mem_be[0], 1);
        toPosedge();
        clearInputs();
        toNegedge();
        checkOutput("C mem_a aligned", mem_a[0], 32'h10);
        toPosedge();
        toNegedge();
        checkOutput("C m1_rvalid", m1_rvalid[0], 1);
        checkOutput("C m1_rdata", m1_rdata[0], 32'hABADBEEF);
        toPosedge();
        toNegedge();
        toPosedge();

        // Arbitration table on both instances from a fresh reset
        doReset();
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 2; d++) begin
                applyStimulus(d, 0, tbl[i].m0_req, 1'b1, 1'b0, 32'h100 + 32'(4*i), $urandom);
                applyStimulus(d, 1, tbl[i].m1_req, 1'b1, 1'b0, 32'h200 + 32'(4*i), $urandom);
            end
            toNegedge();
            checkOutput($sformatf("T%0d rr gnt", i), {m1_gnt[0], m0_gnt[0]}, tbl[i].exp_rr);
            checkOutput($sformatf("T%0d fx gnt", i), {m1_gnt[1], m0_gnt[1]}, tbl[i].exp_fx);
            checkOutput($sformatf("T%0d rr mem_we", i), mem_we[0], (i > 0) && (tbl[i-1].exp_rr != 2'b00));
            checkOutput($sformatf("T%0d fx mem_we", i), mem_we[1], (i > 0) && (tbl[i-1].exp_fx != 2'b00));
            toPosedge();
        end
        clearInputs();
        toNegedge();
        toPosedge();

        // Randomized traffic on both instances against the model
        for (int n = 0; n < NRAND; n++) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++)
                    applyStimulus(d, p, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom);
            toNegedge();
            toPosedge();
        end
        clearInputs();
        repeat (2) begin
            toNegedge();
            toPosedge();
        end

        // Asynchronous reset in the middle of a write (rr) and a read (fx)
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678);
        applyStimulus(1, 1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        toNegedge();
        toPosedge();
        clearInputs();
        #2;
        checkOutput("R mem_we before reset", mem_we[0], 1);
        rst_n = 1'b0;
        #1;
        checkOutput("R mem_we async drop", mem_we[0], 0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("R mem word16 kept", mem[0][16], ref_mem[0][16]);
        rst_n = 1'b1;
        toNegedge();
        checkOutput("R rr rvalid", {m1_rvalid[0], m0_rvalid[0]}, 0);
        checkOutput("R fx rvalid", {m1_rvalid[1], m0_rvalid[1]}, 0);
        toPosedge();
        toNegedge();
        checkOutput("R fx rvalid late", m1_rvalid[1], 0);
        toPosedge();
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        applyStimulus(0, 1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        toNegedge();
        checkOutput("R first grant m0", {m1_gnt[0], m0_gnt[0]}, 2'b01);
        toPosedge();
        clearInputs();
        repeat (3) begin
            toNegedge();
            toPosedge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
